// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM access arbiter.
package sram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone
  } sram_state_t;

  typedef enum logic {
    GrantCpu,
    GrantLdr
  } grant_t;

  localparam int unsigned SRAM_ADDR_W = 20;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Bundles both requester ports and the SRAM-side pins of the arbiter.
interface sram_access_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  import sram_pkg::*;

  logic                   cpu_req;
  logic                   cpu_we;
  logic [AW-1:0]          cpu_addr;
  logic [DW-1:0]          cpu_wdata;
  logic [DW-1:0]          cpu_rdata;
  logic                   cpu_ack;

  logic                   ldr_req;
  logic                   ldr_we;
  logic [AW-1:0]          ldr_addr;
  logic [DW-1:0]          ldr_wdata;
  logic [DW-1:0]          ldr_rdata;
  logic                   ldr_ack;

  logic [SRAM_ADDR_W-1:0] ADDR;
  logic [DW-1:0]          Data_to_SRAM;
  logic [DW-1:0]          Data_from_SRAM;
  logic                   CE;
  logic                   UB;
  logic                   LB;
  logic                   OE;
  logic                   WE;
  logic                   drive_en;

  // Arbiter view.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    output ADDR, Data_to_SRAM, CE, UB, LB, OE, WE, drive_en,
    input  Data_from_SRAM
  );

  // Requesters plus SRAM/tristate side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    input  ADDR, Data_to_SRAM, CE, UB, LB, OE, WE, drive_en,
    output Data_from_SRAM
  );

endinterface

// File: rtl/sram_access_arbiter_rr_grant.sv
// Combinational round-robin tie-break between the CPU and loader requests.
module sram_rr_grant
  import sram_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  grant_t last_grant_i,
  output logic   valid_o,
  output grant_t grant_o
);

  always_comb begin
    valid_o = cpu_req_i | ldr_req_i;
    grant_o = GrantCpu;
    if (cpu_req_i && ldr_req_i) begin
      grant_o = (last_grant_i == GrantCpu) ? GrantLdr : GrantCpu;
    end else if (ldr_req_i) begin
      grant_o = GrantLdr;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the external 1Mx16 SRAM between the CPU and loader ports and sequences
// the active-low strobes with a fixed number of wait states.
module sram_access_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,  // legal range 1..15
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16
) (
  input logic                   Clk,
  input logic                   Reset,
  sram_access_arbiter_if.slave  bus_io
);

  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  sram_state_t   state_q, state_d;
  grant_t        grant_q, grant_d, rr_grant;
  logic          rr_valid;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
  logic [3:0]    cnt_q, cnt_d;

  sram_rr_grant u_rr_grant (
    .cpu_req_i    (bus_io.cpu_req),
    .ldr_req_i    (bus_io.ldr_req),
    .last_grant_i (grant_q),
    .valid_o      (rr_valid),
    .grant_o      (rr_grant)
  );

  // grant_q doubles as last_grant; resetting to the loader lets the CPU win the first tie.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      grant_q     <= GrantLdr;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          if (rr_grant == GrantCpu) begin
            we_d    = bus_io.cpu_we;
            addr_d  = bus_io.cpu_addr;
            wdata_d = bus_io.cpu_wdata;
          end else begin
            we_d    = bus_io.ldr_we;
            addr_d  = bus_io.ldr_addr;
            wdata_d = bus_io.ldr_wdata;
          end
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = CntLoad;
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          // Last strobe cycle: the SRAM output has settled, capture it.
          if (!we_q) begin
            if (grant_q == GrantCpu) cpu_rdata_d = bus_io.Data_from_SRAM;
            else                     ldr_rdata_d = bus_io.Data_from_SRAM;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes decode straight from the state flops so reset releases them immediately.
  assign bus_io.CE           = (state_q == StIdle);
  assign bus_io.UB           = (state_q == StIdle);
  assign bus_io.LB           = (state_q == StIdle);
  assign bus_io.OE           = !((state_q == StAccess) && !we_q);
  assign bus_io.WE           = !((state_q == StAccess) && we_q);
  assign bus_io.drive_en     = we_q && (state_q != StIdle);
  assign bus_io.ADDR         = SRAM_ADDR_W'(addr_q);
  assign bus_io.Data_to_SRAM = wdata_q;
  assign bus_io.cpu_rdata    = cpu_rdata_q;
  assign bus_io.ldr_rdata    = ldr_rdata_q;
  assign bus_io.cpu_ack      = (state_q == StDone) && (grant_q == GrantCpu);
  assign bus_io.ldr_ack      = (state_q == StDone) && (grant_q == GrantLdr);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: WAIT_CYCLES=2 main instance plus 1 and 5 builds.
module tb_sram_access_arbiter;
  import sram_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  sram_access_arbiter_if #(.AW(16), .DW(16)) b2 ();
  sram_access_arbiter_if #(.AW(16), .DW(16)) b1 ();
  sram_access_arbiter_if #(.AW(16), .DW(16)) b5 ();

  sram_access_arbiter #(.WAIT_CYCLES(2), .AW(16), .DW(16)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus_io(b2.slave)
  );
  sram_access_arbiter #(.WAIT_CYCLES(1), .AW(16), .DW(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus_io(b1.slave)
  );
  sram_access_arbiter #(.WAIT_CYCLES(5), .AW(16), .DW(16)) dut5 (
    .Clk(Clk), .Reset(Reset), .bus_io(b5.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus invariants: OE/WE exclusive, drive_en implies OE high, acks exclusive, ADDR[19:16]=0.
  task automatic chk_inv(input string tag, input logic oe, input logic we, input logic de,
                         input logic ca, input logic la, input logic [3:0] hi);
    logic ok;
    ok = !(!oe && !we) && !(de && !oe) && !(ca && la) && (hi == 4'd0);
    chk(tag, 32'(ok), 32'd1);
  endtask

  // Advance n clocks; everything is sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
      chk_inv("inv_w2", b2.OE, b2.WE, b2.drive_en, b2.cpu_ack, b2.ldr_ack, b2.ADDR[19:16]);
      chk_inv("inv_w1", b1.OE, b1.WE, b1.drive_en, b1.cpu_ack, b1.ldr_ack, b1.ADDR[19:16]);
      chk_inv("inv_w5", b5.OE, b5.WE, b5.drive_en, b5.cpu_ack, b5.ldr_ack, b5.ADDR[19:16]);
    end
  endtask

  // One CPU transaction on the W=2 instance; req drops as soon as ack is seen.
  task automatic cpu_txn2(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          output int n, output int oe_low, output int we_low, output int de_cnt,
                          output logic [19:0] s_addr, output logic [15:0] s_data);
    logic done;
    b2.cpu_req   = 1'b1;
    b2.cpu_we    = we;
    b2.cpu_addr  = addr;
    b2.cpu_wdata = wdata;
    n = 0; oe_low = 0; we_low = 0; de_cnt = 0; done = 1'b0;
    s_addr = '0; s_data = '0;
    while (!done && n < 12) begin
      step(1);
      n++;
      if (n == 1) begin
        s_addr = b2.ADDR;
        s_data = b2.Data_to_SRAM;
      end
      if (!b2.OE) oe_low++;
      if (!b2.WE) we_low++;
      if (b2.drive_en) de_cnt++;
      if (b2.cpu_ack) done = 1'b1;
    end
    b2.cpu_req = 1'b0;
  endtask

  initial begin
    int          n, oe_low, we_low, de_cnt, cpu_at, ldr_at, acks, n1, n5;
    logic [19:0] s_addr, a_cpu, a_ldr, a1, a5;
    logic [15:0] s_data;
    logic [3:0]  seq;

    b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = '0; b2.cpu_wdata = '0;
    b2.ldr_req = 0; b2.ldr_we = 0; b2.ldr_addr = '0; b2.ldr_wdata = '0;
    b2.Data_from_SRAM = '0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.ldr_req = 0; b1.ldr_we = 0; b1.ldr_addr = '0; b1.ldr_wdata = '0;
    b1.Data_from_SRAM = '0;
    b5.cpu_req = 0; b5.cpu_we = 0; b5.cpu_addr = '0; b5.cpu_wdata = '0;
    b5.ldr_req = 0; b5.ldr_we = 0; b5.ldr_addr = '0; b5.ldr_wdata = '0;
    b5.Data_from_SRAM = '0;

    // Reset values
    repeat (2) @(negedge Clk);
    chk("rst_strobes", 32'({b2.CE, b2.UB, b2.LB, b2.OE, b2.WE}), 32'h1f);
    chk("rst_drive_en", 32'(b2.drive_en), 32'd0);
    chk("rst_acks", 32'({b2.cpu_ack, b2.ldr_ack}), 32'd0);
    chk("rst_rdata", 32'({b2.cpu_rdata, b2.ldr_rdata}), 32'd0);
    chk("rst_addr", 32'(b2.ADDR), 32'd0);
    chk("rst_wdata", 32'(b2.Data_to_SRAM), 32'd0);
    Reset = 1'b1;
    step(1);
    chk("idle_ce", 32'(b2.CE), 32'd1);

    // 1: CPU read of 0x0003, SRAM returns 0xBEEF
    b2.Data_from_SRAM = 16'hBEEF;
    cpu_txn2(1'b0, 16'h0003, 16'h0000, n, oe_low, we_low, de_cnt, s_addr, s_data);
    chk("t1_ack_edge", 32'(n), 32'd4);
    chk("t1_rdata", 32'(b2.cpu_rdata), 32'hBEEF);
    chk("t1_oe_low", 32'(oe_low), 32'd2);
    chk("t1_we_low", 32'(we_low), 32'd0);
    chk("t1_drive_en", 32'(de_cnt), 32'd0);
    chk("t1_setup_addr", 32'(s_addr), 32'h00003);
    chk("t1_ldr_ack", 32'(b2.ldr_ack), 32'd0);
    step(1);
    chk("t1_ack_pulse", 32'(b2.cpu_ack), 32'd0);
    chk("t1_idle_ce", 32'(b2.CE), 32'd1);

    // 2: CPU write 0x1234 to 0x0010
    b2.Data_from_SRAM = 16'h0BAD;
    cpu_txn2(1'b1, 16'h0010, 16'h1234, n, oe_low, we_low, de_cnt, s_addr, s_data);
    chk("t2_ack_edge", 32'(n), 32'd4);
    chk("t2_we_low", 32'(we_low), 32'd2);
    chk("t2_oe_low", 32'(oe_low), 32'd0);
    chk("t2_drive_en", 32'(de_cnt), 32'd4);
    chk("t2_addr", 32'(s_addr), 32'h00010);
    chk("t2_wdata", 32'(s_data), 32'h1234);
    chk("t2_rdata_held", 32'(b2.cpu_rdata), 32'hBEEF);
    step(1);
    chk("t2_de_release", 32'(b2.drive_en), 32'd0);

    // 3: simultaneous requests straight after reset; CPU first
    Reset = 1'b0;
    step(1);
    Reset = 1'b1;
    b2.Data_from_SRAM = 16'h5A5A;
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 16'h0020;
    b2.ldr_req = 1; b2.ldr_we = 0; b2.ldr_addr = 16'h0030;
    cpu_at = 0; ldr_at = 0; a_cpu = '0; a_ldr = '0;
    for (int i = 1; i <= 20 && (cpu_at == 0 || ldr_at == 0); i++) begin
      step(1);
      if (b2.cpu_ack) begin cpu_at = i; a_cpu = b2.ADDR; b2.cpu_req = 0; end
      if (b2.ldr_ack) begin ldr_at = i; a_ldr = b2.ADDR; b2.ldr_req = 0; end
    end
    chk("t3_cpu_ack_at", 32'(cpu_at), 32'd4);
    chk("t3_ldr_ack_at", 32'(ldr_at), 32'd9);
    chk("t3_cpu_addr", 32'(a_cpu), 32'h00020);
    chk("t3_ldr_addr", 32'(a_ldr), 32'h00030);
    chk("t3_ldr_rdata", 32'(b2.ldr_rdata), 32'h5A5A);
    step(1);

    // 4: both held high; grants alternate CPU/LDR/CPU/LDR (1 = loader)
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 16'h0100;
    b2.ldr_req = 1; b2.ldr_we = 1; b2.ldr_addr = 16'h0200; b2.ldr_wdata = 16'h7777;
    acks = 0; seq = '0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (b2.cpu_ack || b2.ldr_ack) begin
        seq = {seq[2:0], b2.ldr_ack};
        acks++;
      end
    end
    b2.cpu_req = 0; b2.ldr_req = 0;
    chk("t4_ack_count", 32'(acks), 32'd4);
    chk("t4_sequence", 32'(seq), 32'b0101);
    step(1);
    chk("t4_idle_ce", 32'(b2.CE), 32'd1);

    // 5: reset during ACCESS of a write
    b2.cpu_req = 1; b2.cpu_we = 1; b2.cpu_addr = 16'h0040; b2.cpu_wdata = 16'hCAFE;
    step(2);
    chk("t5_we_active", 32'({b2.WE, b2.drive_en}), 32'b01);
    Reset = 1'b0;
    #1;
    chk("t5_strobes_async", 32'({b2.CE, b2.WE, b2.OE}), 32'b111);
    chk("t5_de_async", 32'(b2.drive_en), 32'd0);
    chk("t5_ack_async", 32'(b2.cpu_ack), 32'd0);
    chk("t5_wdata_rst", 32'(b2.Data_to_SRAM), 32'd0);
    b2.cpu_req = 0;
    step(1);
    Reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (b2.cpu_ack || b2.ldr_ack) acks++;
    end
    chk("t5_no_ack", 32'(acks), 32'd0);
    chk("t5_idle_ce", 32'(b2.CE), 32'd1);

    // 6: W=1 and W=5 builds, address changed mid-access
    b1.Data_from_SRAM = 16'h1111;
    b5.Data_from_SRAM = 16'h5555;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 16'h00AA;
    b5.cpu_req = 1; b5.cpu_we = 0; b5.cpu_addr = 16'h00AA;
    n1 = 0; n5 = 0; a1 = '0; a5 = '0;
    for (int i = 1; i <= 12 && (n1 == 0 || n5 == 0); i++) begin
      step(1);
      if (i == 2) begin
        b1.cpu_addr = 16'h0FFF;
        b5.cpu_addr = 16'h0FFF;
      end
      if (b1.cpu_ack && n1 == 0) begin n1 = i; a1 = b1.ADDR; b1.cpu_req = 0; end
      if (b5.cpu_ack && n5 == 0) begin n5 = i; a5 = b5.ADDR; b5.cpu_req = 0; end
    end
    chk("t6_w1_ack_edge", 32'(n1), 32'd3);
    chk("t6_w5_ack_edge", 32'(n5), 32'd7);
    chk("t6_w1_addr_held", 32'(a1), 32'h000AA);
    chk("t6_w5_addr_held", 32'(a5), 32'h000AA);
    chk("t6_w1_rdata", 32'(b1.cpu_rdata), 32'h1111);
    chk("t6_w5_rdata", 32'(b5.cpu_rdata), 32'h5555);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
